// File: rtl/tm1638_key_reader.sv
// Reads the 32-bit key-scan word from a TM1638: sends the read command, releases DIO, clocks in 4 bytes.
// All outputs are registered; the serial clock is clki / (2*CLK_DIV).
module tm1638_key_reader #(
  parameter int         CLK_DIV  = 32,
  parameter int         WAIT_CYC = 64,
  parameter logic [7:0] CMD      = 8'h42
) (
  input  logic        clki,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] keys,
  output logic        stb,
  output logic        sclk,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic        dio_in
);

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYC - 1);
  localparam logic [15:0] GAP_LAST  = 16'(2 * CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_READ,
    S_END,
    S_GAP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic        phase, phase_nxt;
  logic [4:0]  bit_cnt, bit_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [31:0] shift, shift_nxt;
  logic [31:0] keys_nxt;
  logic        busy_nxt, done_nxt, stb_nxt, sclk_nxt, dout_nxt, oe_nxt;
  logic        div_end;

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    keys_nxt  = keys;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    stb_nxt   = stb;
    sclk_nxt  = sclk;
    dout_nxt  = dio_out;
    oe_nxt    = dio_oe;
    div_end   = (div_cnt == DIV_LAST);

    case (state)
      S_IDLE: begin
        div_nxt = 8'd0;
        if (start) begin
          state_nxt = S_CMD;
          stb_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          oe_nxt    = 1'b1;
          dout_nxt  = CMD[0];
          sclk_nxt  = 1'b0;
          phase_nxt = 1'b0;
          bit_nxt   = 5'd0;
        end
      end

      S_CMD: begin
        if (!div_end) begin
          div_nxt = div_cnt + 8'd1;
        end else begin
          div_nxt = 8'd0;
          if (!phase) begin
            phase_nxt = 1'b1;
            sclk_nxt  = 1'b1;
          end else if (bit_cnt == 5'd7) begin
            // Release DIO so the chip can take over the line.
            state_nxt = S_WAIT;
            oe_nxt    = 1'b0;
            dout_nxt  = 1'b1;
            cnt_nxt   = 16'd0;
          end else begin
            bit_nxt   = bit_cnt + 5'd1;
            phase_nxt = 1'b0;
            sclk_nxt  = 1'b0;
            dout_nxt  = CMD[bit_cnt[2:0] + 3'd1];
          end
        end
      end

      S_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_nxt = S_READ;
          sclk_nxt  = 1'b0;
          phase_nxt = 1'b0;
          bit_nxt   = 5'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      S_READ: begin
        if (!div_end) begin
          div_nxt = div_cnt + 8'd1;
        end else begin
          div_nxt = 8'd0;
          if (!phase) begin
            phase_nxt = 1'b1;
            sclk_nxt  = 1'b1;
          end else begin
            // Last high cycle of the bit: the chip's data has had a full half-period to settle.
            shift_nxt = {dio_in, shift[31:1]};
            if (bit_cnt == 5'd31) begin
              state_nxt = S_END;
            end else begin
              bit_nxt   = bit_cnt + 5'd1;
              phase_nxt = 1'b0;
              sclk_nxt  = 1'b0;
            end
          end
        end
      end

      S_END: begin
        if (!div_end) begin
          div_nxt = div_cnt + 8'd1;
        end else begin
          div_nxt   = 8'd0;
          state_nxt = S_GAP;
          stb_nxt   = 1'b1;
          done_nxt  = 1'b1;
          keys_nxt  = shift;
          cnt_nxt   = 16'd0;
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      div_cnt <= 8'd0;
      phase   <= 1'b0;
      bit_cnt <= 5'd0;
      cnt     <= 16'd0;
      shift   <= 32'd0;
      keys    <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      stb     <= 1'b1;
      sclk    <= 1'b1;
      dio_out <= 1'b1;
      dio_oe  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_nxt;
      cnt     <= cnt_nxt;
      shift   <= shift_nxt;
      keys    <= keys_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      stb     <= stb_nxt;
      sclk    <= sclk_nxt;
      dio_out <= dout_nxt;
      dio_oe  <= oe_nxt;
    end
  end

endmodule
